dct_block_sched: RTL and testbench
==================================

// Module: dct_block_sched
// PURPOSE
//  Sequencer for the 1-D DCT datapath of task 13. Pulls input samples from the input buffer
//  (valid/ready), groups them into BLOCK_LEN-sample blocks and zero-pads a short final block.
//  Feeds one block at a time into dct_1d and waits for that block's BLOCK_LEN results.
//  Forwards the results to the output buffer and reports packet completion and answer size.
// PARAMETERS
//  DATA_WIDTH_IN   8    width of input samples / DCT input
//  DATA_WIDTH_OUT  16   width of DCT results
//  BLOCK_LEN       4    samples per DCT block (power of 2, >=2)
//  MAX_BLOCKS      64   max blocks per packet; more = overflow error
//  DRAIN_TIMEOUT   64   max cycles waiting for one block's results
// PORTS
//  i_clk            in   1               clock
//  i_rst            in   1               synchronous reset, active-high
//  i_start          in   1               1-cycle pulse: begin a packet (used only in IDLE)
//  i_src_valid      in   1               input buffer sample valid
//  i_src_data       in   DATA_WIDTH_IN   input sample
//  i_src_last       in   1               sample is the last of the packet
//  o_src_ready      out  1               sample accepted when valid&ready
//  o_dct_valid      out  1               sample strobe to dct_1d
//  o_dct_data       out  DATA_WIDTH_IN   sample to dct_1d (0 while padding)
//  i_dct_valid      in   1               dct_1d result strobe
//  i_dct_data       in   DATA_WIDTH_OUT  dct_1d result
//  i_sink_full      in   1               output buffer cannot take another block
//  o_res_valid      out  1               result to output buffer
//  o_res_data       out  DATA_WIDTH_OUT  result data
//  o_res_last       out  1               last result of the packet
//  o_done           out  1               1-cycle pulse: packet finished
//  o_packet_bytes   out  12              answer size in bytes; valid from o_done until next i_start
//  o_busy           out  1               state != IDLE
//  o_err            out  1               sticky: overflow, timeout or unexpected result; cleared by i_start
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; all counters and flags 0.
//  States: IDLE, WAIT, FEED, PAD, DRAIN, DONE.
//  IDLE: i_start -> WAIT. Clears block count, sample index, last_seen and o_err.
//  WAIT: o_src_ready=0. Moves to FEED on the first cycle with i_sink_full=0.
//  FEED: o_src_ready=1 and sample index idx<BLOCK_LEN. On each handshake:
//   - o_dct_valid=1 and o_dct_data=sample on the next cycle (1-cycle registered latency); idx++.
//   - Handshake at idx==BLOCK_LEN-1 -> DRAIN. If i_src_last is also set, last_seen=1.
//   - i_src_last at idx<BLOCK_LEN-1 -> last_seen=1, then PAD.
//  PAD: o_src_ready=0. One zero sample per cycle with o_dct_valid=1 until idx==BLOCK_LEN, then DRAIN.
//  DRAIN: o_src_ready=0. Count results from i_dct_valid.
//   - Result counter reaches BLOCK_LEN -> block count++.
//   - Then: last_seen -> DONE; otherwise -> WAIT with idx=0.
//  Result forwarding: o_res_valid/o_res_data = i_dct_valid/i_dct_data registered 1 cycle.
//   o_res_last=1 with the BLOCK_LEN-th result of the block in which last_seen=1.
//  DONE: o_done=1 for one cycle; o_packet_bytes = blocks*BLOCK_LEN*DATA_WIDTH_OUT/8; -> IDLE.
//  Errors (all set o_err, which holds until the next i_start):
//   - Block count reaches MAX_BLOCKS without last_seen -> DONE.
//   - DRAIN lasts DRAIN_TIMEOUT cycles -> DONE, with o_res_last forced on a 1-cycle o_res_valid with data 0.
//   - i_dct_valid outside DRAIN -> result dropped, not forwarded; state unchanged.
//  Simultaneous events:
//   - i_start while busy: ignored.
//   - i_src_valid in any state but FEED: not accepted, because o_src_ready=0.
//   - i_sink_full has no effect once a block has left WAIT; the buffer must reserve space for the whole block.
//  Reset mid-operation: immediate return to IDLE, no o_done. The DCT core shares i_rst.
// STRUCTURE
//  Package task_13_pkg:
//   - typedef enum logic [2:0] sched_state_t
//   - localparams IDX_W=$clog2(BLOCK_LEN+1) and BLK_W=$clog2(MAX_BLOCKS+1)
//   - function bytes_of(blocks)
//  One sub-module, dct_sched_cnt: a generic up-counter with clear/enable/terminal-count.
//   Instantiated three times: sample index, result count, timeout.
//  FSM and output registers live in dct_block_sched.
// TESTING
//  1 Start, 8 samples 1..8 with last on 8, dct_1d model -> 2 blocks fed, no padding,
//    8 results, o_res_last on the 8th, o_done, o_packet_bytes=16.
//  2 Start, 5 samples with last on 5 -> block 2 is sample5,0,0,0 (3 PAD cycles),
//    o_packet_bytes=16, o_err=0.
//  3 i_sink_full=1 for 10 cycles after block 1 -> stays in WAIT, o_src_ready=0,
//    then resumes and matches the case-1 result stream.
//  4 Core model drops one result -> o_err=1 and o_done exactly DRAIN_TIMEOUT cycles after DRAIN entry;
//    the next i_start clears o_err.
//  5 Never assert last, 260 samples -> o_err at block 64, o_packet_bytes=512;
//    extra i_dct_valid pulses in IDLE are not forwarded.
//  6 i_rst asserted mid-FEED at idx=2 -> next cycle all outputs 0, o_busy=0;
//    a new packet then runs as in case 1.

Source files
------------

// File: rtl/task_13_pkg.sv
// Shared types and helpers for the 1-D DCT block scheduler.
package task_13_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FEED  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_t;

  localparam int DEF_DATA_WIDTH_IN  = 8;
  localparam int DEF_DATA_WIDTH_OUT = 16;
  localparam int DEF_BLOCK_LEN      = 4;
  localparam int DEF_MAX_BLOCKS     = 64;
  localparam int DEF_DRAIN_TIMEOUT  = 64;

  localparam int IDX_W = $clog2(DEF_BLOCK_LEN + 1);
  localparam int BLK_W = $clog2(DEF_MAX_BLOCKS + 1);

  // Answer size in bytes for a given number of completed blocks.
  function automatic logic [11:0] bytes_of(input int blocks, input int block_len,
                                           input int width_out);
    return 12'(blocks * block_len * width_out / 8);
  endfunction

endpackage

// File: rtl/dct_sched_cnt.sv
// Generic up-counter with synchronous clear, enable and terminal-count flag.
module dct_sched_cnt #(
  parameter int W  = 3,
  parameter int TC = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(TC));

endmodule

// File: rtl/dct_block_sched.sv
// Block sequencer between the input buffer, the dct_1d core and the output buffer.
// state | meaning: IDLE wait start, WAIT sink space, FEED pass samples, PAD zero fill,
//       DRAIN collect results, DONE one-cycle completion pulse.
module dct_block_sched
  import task_13_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = DEF_DATA_WIDTH_IN,
  parameter int DATA_WIDTH_OUT = DEF_DATA_WIDTH_OUT,
  parameter int BLOCK_LEN      = DEF_BLOCK_LEN,
  parameter int MAX_BLOCKS     = DEF_MAX_BLOCKS,
  parameter int DRAIN_TIMEOUT  = DEF_DRAIN_TIMEOUT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_src_valid,
  input  logic [DATA_WIDTH_IN-1:0]  i_src_data,
  input  logic                      i_src_last,
  output logic                      o_src_ready,
  output logic                      o_dct_valid,
  output logic [DATA_WIDTH_IN-1:0]  o_dct_data,
  input  logic                      i_dct_valid,
  input  logic [DATA_WIDTH_OUT-1:0] i_dct_data,
  input  logic                      i_sink_full,
  output logic                      o_res_valid,
  output logic [DATA_WIDTH_OUT-1:0] o_res_data,
  output logic                      o_res_last,
  output logic                      o_done,
  output logic [11:0]               o_packet_bytes,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int W_IDX = $clog2(BLOCK_LEN + 1);
  localparam int W_BLK = $clog2(MAX_BLOCKS + 1);
  localparam int W_TMO = $clog2(DRAIN_TIMEOUT + 1);

  sched_state_t              r_state;
  logic                      r_src_ready;
  logic                      r_dct_valid;
  logic [DATA_WIDTH_IN-1:0]  r_dct_data;
  logic                      r_res_valid;
  logic [DATA_WIDTH_OUT-1:0] r_res_data;
  logic                      r_res_last;
  logic                      r_done;
  logic [11:0]               r_packet_bytes;
  logic                      r_busy;
  logic                      r_err;
  logic [W_BLK-1:0]          r_blocks;
  logic                      r_last_seen;

  logic [W_IDX-1:0] w_idx;
  logic [W_IDX-1:0] w_res_cnt;
  logic [W_TMO-1:0] w_tmo_cnt;
  logic             w_idx_tc;
  logic             w_res_tc;
  logic             w_tmo_tc;
  logic             w_hs;
  logic             w_in_drain;
  logic             w_res_hit;
  logic             w_blk_done;
  logic [W_BLK-1:0] w_blocks_inc;
  logic             w_unused;

  assign w_in_drain   = (r_state == ST_DRAIN);
  assign w_hs         = i_src_valid & r_src_ready & (w_idx < W_IDX'(BLOCK_LEN));
  assign w_res_hit    = w_in_drain & i_dct_valid;
  assign w_blk_done   = w_res_hit & w_res_tc;
  assign w_blocks_inc = r_blocks + 1'b1;
  assign w_unused     = ^{w_res_cnt, w_tmo_cnt};

  dct_sched_cnt #(.W(W_IDX), .TC(BLOCK_LEN - 1)) u_idx_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr ((r_state == ST_IDLE) || (r_state == ST_WAIT)),
    .i_en  (w_hs || (r_state == ST_PAD)),
    .o_cnt (w_idx),
    .o_tc  (w_idx_tc)
  );

  dct_sched_cnt #(.W(W_IDX), .TC(BLOCK_LEN - 1)) u_res_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (!w_in_drain),
    .i_en  (w_res_hit),
    .o_cnt (w_res_cnt),
    .o_tc  (w_res_tc)
  );

  dct_sched_cnt #(.W(W_TMO), .TC(DRAIN_TIMEOUT - 1)) u_tmo_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (!w_in_drain),
    .i_en  (w_in_drain),
    .o_cnt (w_tmo_cnt),
    .o_tc  (w_tmo_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_src_ready    <= 1'b0;
      r_dct_valid    <= 1'b0;
      r_dct_data     <= '0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_last     <= 1'b0;
      r_done         <= 1'b0;
      r_packet_bytes <= '0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
      r_blocks       <= '0;
      r_last_seen    <= 1'b0;
    end else begin
      r_dct_valid <= 1'b0;
      r_dct_data  <= '0;
      r_done      <= 1'b0;
      r_res_valid <= w_res_hit;
      r_res_data  <= w_res_hit ? i_dct_data : '0;
      r_res_last  <= w_blk_done & r_last_seen;
      // Results arriving outside DRAIN are dropped and flagged.
      if (i_dct_valid && !w_in_drain) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state        <= ST_WAIT;
            r_busy         <= 1'b1;
            r_blocks       <= '0;
            r_last_seen    <= 1'b0;
            r_err          <= 1'b0;
            r_packet_bytes <= '0;
          end
        end
        ST_WAIT: begin
          if (!i_sink_full) begin
            r_state     <= ST_FEED;
            r_src_ready <= 1'b1;
          end
        end
        ST_FEED: begin
          if (w_hs) begin
            r_dct_valid <= 1'b1;
            r_dct_data  <= i_src_data;
            if (w_idx_tc) begin
              r_state     <= ST_DRAIN;
              r_src_ready <= 1'b0;
              if (i_src_last) r_last_seen <= 1'b1;
            end else if (i_src_last) begin
              r_state     <= ST_PAD;
              r_src_ready <= 1'b0;
              r_last_seen <= 1'b1;
            end
          end
        end
        ST_PAD: begin
          r_dct_valid <= 1'b1;
          if (w_idx_tc) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_blk_done) begin
            r_blocks <= w_blocks_inc;
            if (r_last_seen || (w_blocks_inc == W_BLK'(MAX_BLOCKS))) begin
              if (!r_last_seen) r_err <= 1'b1;
              r_state        <= ST_DONE;
              r_done         <= 1'b1;
              r_packet_bytes <= bytes_of(int'(w_blocks_inc), BLOCK_LEN, DATA_WIDTH_OUT);
            end else begin
              r_state <= ST_WAIT;
            end
          end else if (w_tmo_tc) begin
            // Core stalled: close the packet with a zero terminator result.
            r_err          <= 1'b1;
            r_res_valid    <= 1'b1;
            r_res_data     <= '0;
            r_res_last     <= 1'b1;
            r_state        <= ST_DONE;
            r_done         <= 1'b1;
            r_packet_bytes <= bytes_of(int'(r_blocks), BLOCK_LEN, DATA_WIDTH_OUT);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_src_ready    = r_src_ready;
  assign o_dct_valid    = r_dct_valid;
  assign o_dct_data     = r_dct_data;
  assign o_res_valid    = r_res_valid;
  assign o_res_data     = r_res_data;
  assign o_res_last     = r_res_last;
  assign o_done         = r_done;
  assign o_packet_bytes = r_packet_bytes;
  assign o_busy         = r_busy;
  assign o_err          = r_err;

endmodule

// File: tb/tb_dct_block_sched.sv
// Bench for dct_block_sched: packet vectors against a simple dct_1d stand-in.
module tb_dct_block_sched;

  localparam int BL  = 4;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = '0;
  logic        src_last = 1'b0;
  logic        sink_full = 1'b0;
  logic        core_v = 1'b0;
  logic [15:0] core_d = '0;
  logic        inj_v = 1'b0;
  logic [15:0] inj_d = '0;
  logic        dct_vin;
  logic [15:0] dct_din;

  logic        o_src_ready, o_dct_valid, o_res_valid, o_res_last;
  logic        o_done, o_busy, o_err;
  logic [7:0]  o_dct_data;
  logic [15:0] o_res_data;
  logic [11:0] o_packet_bytes;

  assign dct_vin = core_v | inj_v;
  assign dct_din = core_v ? core_d : inj_d;

  dct_block_sched dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_src_valid    (src_valid),
    .i_src_data     (src_data),
    .i_src_last     (src_last),
    .o_src_ready    (o_src_ready),
    .o_dct_valid    (o_dct_valid),
    .o_dct_data     (o_dct_data),
    .i_dct_valid    (dct_vin),
    .i_dct_data     (dct_din),
    .i_sink_full    (sink_full),
    .o_res_valid    (o_res_valid),
    .o_res_data     (o_res_data),
    .o_res_last     (o_res_last),
    .o_done         (o_done),
    .o_packet_bytes (o_packet_bytes),
    .o_busy         (o_busy),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] samp(input int i);
    return 8'((i % 255) + 1);
  endfunction

  // Observation of DUT outputs, plus the sink-full window armed by a vector.
  logic [15:0] got_d[$];
  bit          got_l[$];
  int dct_cnt, pad_cnt, done_cnt, done_cyc, drain_cyc, done_bytes, done_err;
  int full_left = 0;
  int ready_viol = 0;
  bit full_arm = 1'b0;
  bit drop_next = 1'b0;

  initial forever begin
    @(negedge clk);
    if (o_res_valid) begin
      got_d.push_back(o_res_data);
      got_l.push_back(o_res_last);
    end
    if (o_dct_valid) begin
      dct_cnt++;
      if (o_dct_data == 8'd0) pad_cnt++;
      if (dct_cnt == BL) drain_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc   = cyc;
      done_bytes = int'(o_packet_bytes);
      done_err   = int'(o_err);
    end
    if (full_left > 0) begin
      if (o_src_ready) ready_viol++;
      full_left--;
      if (full_left == 0) sink_full = 1'b0;
    end else if (full_arm && o_dct_valid && dct_cnt == BL) begin
      sink_full = 1'b1;
      full_left = 10;
      full_arm  = 1'b0;
    end
  end

  // dct_1d stand-in: result k of a block is {k, sample k}, two cycles after the block.
  initial begin
    logic [7:0] blk [BL];
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n = 0;
      end else if (o_dct_valid) begin
        blk[n] = o_dct_data;
        n++;
        if (n == BL) begin
          n = 0;
          repeat (2) @(negedge clk);
          for (int k = 0; k < BL; k++) begin
            if (!(drop_next && k == BL - 1)) begin
              core_v = 1'b1;
              core_d = {8'(k), blk[k]};
            end
            @(negedge clk);
            core_v = 1'b0;
          end
          drop_next = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic clear_mon();
    got_d.delete();
    got_l.delete();
    dct_cnt = 0; pad_cnt = 0; done_cnt = 0;
    done_cyc = -1; drain_cyc = -1; done_bytes = -1; done_err = -1;
    ready_viol = 0;
  endtask

  task automatic pulse_start(input string nm);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_err_cleared"}, o_err, 0);
    chk({nm, "_busy_after_start"}, o_busy, 1);
  endtask

  task automatic send(input int n, input bit with_last, input int budget, output int acc);
    int t;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      src_valid = 1'b1;
      src_data  = samp(i);
      src_last  = with_last && (i == n - 1);
      t = 0;
      while (!o_src_ready && t < budget) begin
        @(negedge clk);
        t++;
      end
      if (!o_src_ready) break;
      @(negedge clk);
      acc++;
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int t;
    t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_done_within_budget"}, done_cnt > 0, 1);
  endtask

  typedef struct {
    int n;
    bit lst;
    bit full;
    bit drop;
    int bytes;
    int err;
    int pad;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int acc, nb, lastcnt, lastpos;
    logic [15:0] e[$];
    clear_mon();
    drop_next = v.drop;
    full_arm  = v.full;
    pulse_start(nm);
    send(v.n, v.lst, 300, acc);
    chk({nm, "_accepted"}, acc, v.n);
    wait_done(nm, 300);
    repeat (4) @(negedge clk);

    nb = (v.n + BL - 1) / BL;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < BL; k++)
        e.push_back({8'(k), (b * BL + k < v.n) ? samp(b * BL + k) : 8'd0});
    if (v.drop) begin
      e.delete(BL - 1);
      e.push_back(16'h0000);
    end

    chk({nm, "_result_count"}, got_d.size(), e.size());
    for (int i = 0; i < e.size() && i < got_d.size(); i++)
      chk($sformatf("%s_result%0d", nm, i), got_d[i], e[i]);
    lastcnt = 0; lastpos = -1;
    foreach (got_l[i]) if (got_l[i]) begin lastcnt++; lastpos = i; end
    chk({nm, "_last_count"}, lastcnt, 1);
    chk({nm, "_last_pos"}, lastpos, e.size() - 1);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_bytes"}, done_bytes, v.bytes);
    chk({nm, "_err"}, done_err, v.err);
    chk({nm, "_pad"}, pad_cnt, v.pad);
    chk({nm, "_idle_busy"}, o_busy, 0);
    if (v.full) chk({nm, "_ready_while_full"}, ready_viol, 0);
    if (v.drop) chk({nm, "_timeout_cycles"}, done_cyc - drain_cyc, TMO);
  endtask

  vec_t vecs[6];

  initial begin
    int acc, sz;
    longint outs;
    vecs[0] = '{n: 8, lst: 1, full: 0, drop: 0, bytes: 16, err: 0, pad: 0};
    vecs[1] = '{n: 5, lst: 1, full: 0, drop: 0, bytes: 16, err: 0, pad: 3};
    vecs[2] = '{n: 8, lst: 1, full: 1, drop: 0, bytes: 16, err: 0, pad: 0};
    vecs[3] = '{n: 4, lst: 1, full: 0, drop: 1, bytes: 0,  err: 1, pad: 0};
    vecs[4] = '{n: 4, lst: 1, full: 0, drop: 0, bytes: 8,  err: 0, pad: 0};
    vecs[5] = '{n: 1, lst: 1, full: 0, drop: 0, bytes: 8,  err: 0, pad: 3};

    repeat (3) @(negedge clk);
    outs = {o_src_ready, o_dct_valid, o_dct_data, o_res_valid, o_res_data,
            o_res_last, o_done, o_packet_bytes, o_busy, o_err};
    chk("reset_outputs", outs, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Never-ending packet: overflow at MAX_BLOCKS, then stray results in IDLE.
    clear_mon();
    pulse_start("ovf");
    send(260, 1'b0, 100, acc);
    chk("ovf_accepted", acc, 256);
    repeat (4) @(negedge clk);
    chk("ovf_done_pulses", done_cnt, 1);
    chk("ovf_bytes", done_bytes, 512);
    chk("ovf_err", done_err, 1);
    chk("ovf_result_count", got_d.size(), 256);
    chk("ovf_last_count", got_l.sum() with (int'(item)), 0);
    sz = got_d.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inj_v = 1'b1;
      inj_d = 16'hBEEF;
      @(negedge clk);
      inj_v = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("idle_stray_not_forwarded", got_d.size(), sz);
    chk("idle_stray_err", o_err, 1);
    chk("idle_busy", o_busy, 0);

    // Reset in the middle of FEED with two samples taken.
    clear_mon();
    pulse_start("rst_mid");
    send(2, 1'b0, 50, acc);
    chk("rst_mid_accepted", acc, 2);
    rst = 1'b1;
    @(negedge clk);
    outs = {o_src_ready, o_dct_valid, o_dct_data, o_res_valid, o_res_data,
            o_res_last, o_done, o_packet_bytes, o_busy, o_err};
    chk("rst_mid_outputs", outs, 0);
    chk("rst_mid_no_done", done_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
